// File: rtl/branch_predict_resolve_if.sv
// Fetch-side prediction and EX-side resolution signals of branch_predict_resolve.
// master drives the fetch PC and the EX-stage instruction; slave is the predictor/resolver.
interface branch_predict_resolve_if #(
  parameter int XLEN     = 32,
  parameter int CNT_BITS = 16
);
  logic [XLEN-1:0]     fetch_pc;
  logic                pred_taken;
  logic                ex_valid;
  logic [XLEN-1:0]     ex_inst;
  logic [XLEN-1:0]     ex_pc;
  logic                ex_pred;
  logic                ex_taken;
  logic [1:0]          flush_in;
  logic                pcsel;
  logic [1:0]          flush;
  logic [CNT_BITS-1:0] mispredict_cnt;

  modport master (
    output fetch_pc, ex_valid, ex_inst, ex_pc, ex_pred, ex_taken, flush_in,
    input  pred_taken, pcsel, flush, mispredict_cnt
  );

  modport slave (
    input  fetch_pc, ex_valid, ex_inst, ex_pc, ex_pred, ex_taken, flush_in,
    output pred_taken, pcsel, flush, mispredict_cnt
  );
endinterface

// File: rtl/branch_predict_resolve.sv
// Bimodal/gshare PHT of saturating counters: zero-latency fetch prediction plus EX-stage
// branch resolution (PC select, IF/ID + ID/EX flush), PHT/history training, mispredict count.
module branch_predict_resolve #(
  parameter int XLEN       = 32,
  parameter int INDEX_BITS = 6,
  parameter int CTR_BITS   = 2,
  parameter int GHR_BITS   = 0,
  parameter int CNT_BITS   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  branch_predict_resolve_if.slave bus
);
  localparam int DEPTH = 1 << INDEX_BITS;
  localparam int GW    = (GHR_BITS > 0) ? GHR_BITS : 1;
  localparam logic [CTR_BITS-1:0] CTR_MAX  = CTR_BITS'((1 << CTR_BITS) - 1);
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  typedef enum logic [1:0] {
    CLS_OTHER,
    CLS_BR,
    CLS_JAL,
    CLS_JALR
  } inst_class_e;

  logic [CTR_BITS-1:0]   pht [DEPTH];
  logic [GW-1:0]         ghr;
  logic [INDEX_BITS-1:0] ghr_ext;
  logic [INDEX_BITS-1:0] fetch_idx;
  logic [INDEX_BITS-1:0] ex_idx;
  logic [CNT_BITS-1:0]   miss_cnt;
  inst_class_e           cls;
  logic                  is_br;
  logic                  mispredict;

  generate
    if (GHR_BITS > 0) begin : g_ghr_idx
      assign ghr_ext = INDEX_BITS'(ghr);
    end else begin : g_no_ghr_idx
      assign ghr_ext = '0;
    end
  endgenerate

  assign fetch_idx = bus.fetch_pc[INDEX_BITS+1:2] ^ ghr_ext;
  assign ex_idx    = bus.ex_pc[INDEX_BITS+1:2] ^ ghr_ext;

  // Read is taken from the registered array, so a same-cycle write is not bypassed.
  assign bus.pred_taken     = pht[fetch_idx][CTR_BITS-1];
  assign bus.mispredict_cnt = miss_cnt;

  // case equality keeps unknown opcode bits out of the BR class.
  always_comb begin
    cls = CLS_OTHER;
    case (bus.ex_inst[6:0])
      OP_BR:   cls = CLS_BR;
      OP_JAL:  cls = CLS_JAL;
      OP_JALR: cls = CLS_JALR;
      default: cls = CLS_OTHER;
    endcase
  end

  assign is_br      = bus.ex_valid && (cls == CLS_BR);
  assign mispredict = is_br && (bus.ex_pred != bus.ex_taken);

  always_comb begin
    bus.pcsel = 1'b1;
    bus.flush = bus.flush_in;
    if (rst) begin
      bus.flush = 2'b00;
    end else if (bus.ex_valid) begin
      case (cls)
        CLS_BR: begin
          bus.pcsel = !mispredict;
          bus.flush = mispredict ? 2'b11 : 2'b00;
        end
        CLS_JAL, CLS_JALR: begin
          bus.pcsel = 1'b0;
          bus.flush = 2'b11;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pht[i] <= CTR_INIT;
      end
    end else if (is_br) begin
      if (bus.ex_taken && (pht[ex_idx] != CTR_MAX)) begin
        pht[ex_idx] <= pht[ex_idx] + 1'b1;
      end else if (!bus.ex_taken && (pht[ex_idx] != '0)) begin
        pht[ex_idx] <= pht[ex_idx] - 1'b1;
      end
    end
  end

  generate
    if (GHR_BITS > 1) begin : g_ghr_shift
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ghr <= '0;
        end else if (is_br) begin
          ghr <= {ghr[GW-2:0], bus.ex_taken};
        end
      end
    end else if (GHR_BITS == 1) begin : g_ghr_bit
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ghr <= '0;
        end else if (is_br) begin
          ghr <= bus.ex_taken;
        end
      end
    end else begin : g_ghr_none
      assign ghr = '0;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miss_cnt <= '0;
    end else if (mispredict && (miss_cnt != '1)) begin
      miss_cnt <= miss_cnt + 1'b1;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{bus.fetch_pc[XLEN-1:INDEX_BITS+2], bus.fetch_pc[1:0],
                         bus.ex_pc[XLEN-1:INDEX_BITS+2], bus.ex_pc[1:0],
                         bus.ex_inst[XLEN-1:7], ghr};
endmodule
